// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised RV32I integer register file with a per-register busy
// scoreboard for RAW hazard detection and a sequential post-reset clear sequence.
//
// Optional feature (macro REGFILE_WB_BYPASS_EN): write-through bypass from the write-back
// port to the read ports in the same cycle.
//
// Parameter constraints: 2 <= REGFILE_DEPTH <= 2**REGFILE_ADDR_WIDTH, NUM_READ_PORTS >= 1.
//
// Ports:
//   Clk_100MHz        in   system clock, rising edge
//   Reset             in   synchronous active-high reset
//   Rs_address        in   packed read addresses, port k at [k*AW +: AW]
//   Rs_data           out  packed read data, port k at [k*DW +: DW]
//   Rs_busy           out  per-port busy bit of the addressed register
//   Issue_en          in   instruction writing Issue_rd_address issued this cycle
//   Issue_rd_address  in   destination register of the issued instruction
//   Rd_wr_en          in   write-back write enable
//   Rd_address        in   write-back destination
//   Rd_wr_data        in   write-back data
//   Ready             out  clear sequence complete, traffic accepted
module regfile_scoreboard #(
   parameter int unsigned REG_DATA_WIDTH     = 32,
   parameter int unsigned REGFILE_ADDR_WIDTH = 5,
   parameter int unsigned REGFILE_DEPTH      = 32,
   parameter int unsigned NUM_READ_PORTS     = 2
) (
   input  logic                                         Clk_100MHz,
   input  logic                                         Reset,
   input  logic [NUM_READ_PORTS*REGFILE_ADDR_WIDTH-1:0] Rs_address,
   output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0]     Rs_data,
   output logic [NUM_READ_PORTS-1:0]                    Rs_busy,
   input  logic                                         Issue_en,
   input  logic [REGFILE_ADDR_WIDTH-1:0]                Issue_rd_address,
   input  logic                                         Rd_wr_en,
   input  logic [REGFILE_ADDR_WIDTH-1:0]                Rd_address,
   input  logic [REG_DATA_WIDTH-1:0]                    Rd_wr_data,
   output logic                                         Ready
);

   localparam int unsigned AW = REGFILE_ADDR_WIDTH;
   localparam int unsigned DW = REG_DATA_WIDTH;
   // One extra bit so REGFILE_DEPTH == 2**AW is representable.
   localparam logic [AW:0]   DepthW  = (AW+1)'(REGFILE_DEPTH);
   localparam logic [AW-1:0] LastIdx = AW'(REGFILE_DEPTH - 1);

   typedef enum logic {StClear, StRun} state_e;

   state_e                  state_q, state_d;
   logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
   logic [REGFILE_DEPTH-1:0] busy_q, busy_d;
   logic [DW-1:0]           mem_q [REGFILE_DEPTH];

   logic run;
   logic wr_valid;
   logic iss_valid;

   // Nonzero and backed by a physical entry.
   function automatic logic addr_ok(input logic [AW-1:0] addr);
      return (addr != '0) && ({1'b0, addr} < DepthW);
   endfunction

   assign run       = (state_q == StRun);
   assign Ready     = run;
   assign wr_valid  = run && Rd_wr_en && addr_ok(Rd_address);
   assign iss_valid = run && Issue_en && addr_ok(Issue_rd_address);

   // Clear sequencer: one entry per cycle, then RUN.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LastIdx) begin
               state_d = StRun;
            end
         end
         default: ;
      endcase
   end

   // Issue is applied after the write-back clear so a same-address issue wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_valid) begin
         busy_d[Rd_address] = 1'b0;
      end
      if (iss_valid) begin
         busy_d[Issue_rd_address] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge Clk_100MHz) begin
      if (Reset) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Array has no reset; the clear sequence rewrites it.
   always_ff @(posedge Clk_100MHz) begin
      if (!Reset) begin
         if (state_q == StClear) begin
            mem_q[clr_cnt_q] <= '0;
         end else if (wr_valid) begin
            mem_q[Rd_address] <= Rd_wr_data;
         end
      end
   end

   for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : gen_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          busy;

      assign addr = Rs_address[k*AW +: AW];

      always_comb begin
         data = '0;
         busy = 1'b0;
         if (run && addr_ok(addr)) begin
            data = mem_q[addr];
            busy = busy_q[addr];
`ifdef REGFILE_WB_BYPASS_EN
            // Show the post-edge view of the register being written back.
            if (wr_valid && (Rd_address == addr)) begin
               data = Rd_wr_data;
               busy = iss_valid && (Issue_rd_address == addr);
            end
`else
`endif
         end
      end

      assign Rs_data[k*DW +: DW] = data;
      assign Rs_busy[k]          = busy;
   end

endmodule
